// File: rtl/apb_to_fll_multi_pkg.sv
// Shared types and constants for the multi-channel APB-to-FLL configuration bridge.
package apb_to_fll_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK_LOW,
    ST_DRAIN
  } state_e;

  localparam int FLL_REG_IDX_LSB = 2;
  localparam int FLL_CH_LSB      = 6;

  typedef struct packed {
    logic        web;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } fll_req_t;

  localparam fll_req_t FLL_REQ_IDLE = '{web: 1'b1, addr: 4'h0, wdata: 32'h0};

  // $clog2 that never returns 0, so a single channel or counter value still gets one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fll_ack_sync.sv
// Single-bit multi-flop synchroniser bringing an FLL ack into the clk_i domain.
module fll_ack_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_ack,
  output logic o_ack_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ack};
    end
  end

  assign o_ack_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/apb_to_fll_multi.sv
// APB slave fanning out to NUM_FLL FLL config ports over a 4-phase req/ack handshake.
module apb_to_fll_multi
  import apb_to_fll_multi_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_FLL        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [NUM_FLL-1:0]        fll_req_o,
  output logic [NUM_FLL-1:0]        fll_web_o,
  output logic [NUM_FLL*4-1:0]      fll_addr_o,
  output logic [NUM_FLL*32-1:0]     fll_wdata_o,
  input  logic [NUM_FLL-1:0]        fll_ack_i,
  input  logic [NUM_FLL*32-1:0]     fll_rdata_i
);

  localparam int CH_W  = clog2_min1(NUM_FLL);
  localparam int CH_HI = FLL_CH_LSB + CH_W;
  localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [CH_W-1:0]   r_ch;
  fll_req_t          r_req;
  logic [CNT_W-1:0]  r_cnt;

  logic [CH_W-1:0]   w_ch;
  logic              w_access;
  logic              w_hi_set;
  logic              w_unmapped;
  logic              w_accept;
  logic [NUM_FLL-1:0] w_ack_sync;
  logic              w_ack_sel;
  logic [31:0]       w_rdata_sel;
  logic              w_unused;

  assign w_unused = ^paddr_i[FLL_REG_IDX_LSB-1:0];

  for (genvar g = 0; g < NUM_FLL; g++) begin : g_sync
    fll_ack_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .i_ack     (fll_ack_i[g]),
      .o_ack_sync(w_ack_sync[g])
    );
  end

  // Address bits above the channel field alias nothing, so any set bit is an unmapped access.
  if (APB_ADDR_WIDTH > CH_HI) begin : g_hi
    assign w_hi_set = |paddr_i[APB_ADDR_WIDTH-1:CH_HI];
  end else begin : g_no_hi
    assign w_hi_set = 1'b0;
  end

  assign w_ch       = paddr_i[CH_HI-1:FLL_CH_LSB];
  assign w_access   = psel_i & penable_i;
  assign w_unmapped = (int'(w_ch) >= NUM_FLL) | w_hi_set;
  assign w_accept   = (r_state == ST_IDLE) & w_access & ~w_unmapped;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_ack_sel   = 1'b0;
    w_rdata_sel = 32'h0;
    for (int i = 0; i < NUM_FLL; i++) begin
      if (int'(r_ch) == i) begin
        w_ack_sel   = w_ack_sync[i];
        w_rdata_sel = fll_rdata_i[i*32 +: 32];
      end
    end
  end

  // Channel fields come from the registered request so a dropped psel cannot disturb the FLL.
  always_comb begin
    fll_req_o   = '0;
    fll_web_o   = '1;
    fll_addr_o  = '0;
    fll_wdata_o = '0;
    if (r_state == ST_REQ) begin
      for (int i = 0; i < NUM_FLL; i++) begin
        if (int'(r_ch) == i) begin
          fll_req_o[i]            = 1'b1;
          fll_web_o[i]            = r_req.web;
          fll_addr_o[i*4 +: 4]    = r_req.addr;
          fll_wdata_o[i*32 +: 32] = r_req.wdata;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    pready_o     = 1'b0;
    pslverr_o    = 1'b0;
    prdata_o     = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_unmapped) begin
            pready_o  = 1'b1;
            pslverr_o = 1'b1;
          end else begin
            w_state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (w_ack_sel) begin
          pready_o     = w_access;
          prdata_o     = (w_access && r_req.web) ? w_rdata_sel : 32'h0;
          w_state_next = ST_ACK_LOW;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
          pready_o     = w_access;
          pslverr_o    = w_access;
          w_state_next = ST_DRAIN;
        end
      end
      ST_ACK_LOW, ST_DRAIN: begin
        if (!w_ack_sel) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_req   <= FLL_REQ_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_ch  <= w_ch;
        r_req <= '{web:   ~pwrite_i,
                   addr:  paddr_i[FLL_REG_IDX_LSB +: 4],
                   wdata: pwdata_i};
        r_cnt <= '0;
      end else if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_to_fll_multi.sv
// Self-checking bench: table-driven APB transfers against a behavioural FLL model, plus corner sequences.
module tb_apb_to_fll_multi;

  localparam int NUM  = 4;
  localparam int SYNC = 2;
  localparam int TO   = 16;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [11:0]       paddr_i = '0;
  logic [31:0]       pwdata_i = '0;
  logic [31:0]       prdata_o;
  logic              pready_o, pslverr_o;
  logic [NUM-1:0]    fll_req_o, fll_web_o, fll_ack_i;
  logic [NUM*4-1:0]  fll_addr_o;
  logic [NUM*32-1:0] fll_wdata_o, fll_rdata_i;

  // second instance with a non-power-of-two channel count
  logic              psel3 = 1'b0;
  logic [31:0]       prdata3;
  logic              pready3, pslverr3;
  logic [2:0]        req3, web3;
  logic [11:0]       addr3;
  logic [95:0]       wdata3;

  always #5 clk_i = ~clk_i;

  apb_to_fll_multi #(
    .APB_ADDR_WIDTH(12), .NUM_FLL(NUM), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
    .pready_o(pready_o), .pslverr_o(pslverr_o), .fll_req_o(fll_req_o), .fll_web_o(fll_web_o),
    .fll_addr_o(fll_addr_o), .fll_wdata_o(fll_wdata_o), .fll_ack_i(fll_ack_i),
    .fll_rdata_i(fll_rdata_i)
  );

  apb_to_fll_multi #(
    .APB_ADDR_WIDTH(12), .NUM_FLL(3), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)
  ) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .psel_i(psel3), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata3),
    .pready_o(pready3), .pslverr_o(pslverr3), .fll_req_o(req3), .fll_web_o(web3),
    .fll_addr_o(addr3), .fll_wdata_o(wdata3), .fll_ack_i(3'b000), .fll_rdata_i(96'h0)
  );

  int nchecks = 0;
  int nerrors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- FLL model: ack after dly[i] cycles of req, drop ack once req falls
  logic [NUM-1:0] model_ack;
  logic [NUM-1:0] force_ack = '0;
  logic [31:0]    model_rdata [NUM];
  logic [31:0]    regs [NUM][16];
  bit             wrt [NUM][16];
  int             dly [NUM] = '{2, 4, 3, 1};
  bit             mute [NUM] = '{default: 1'b0};
  int             cnt [NUM];
  logic [3:0]     ma;

  function automatic logic [31:0] dflt(input int ch, input logic [3:0] a);
    if (ch == 1 && a == 4'd3)  return 32'h1234_5678;
    if (ch == 3 && a == 4'd15) return 32'hC0FF_EE03;
    return {16'hF11A, 8'(ch), 4'h0, a};
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      model_ack <= '0;
      for (int i = 0; i < NUM; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (fll_req_o[i] && !model_ack[i]) begin
          if (!mute[i]) begin
            cnt[i] <= cnt[i] + 1;
            if (cnt[i] + 1 == dly[i]) begin
              ma = fll_addr_o[i*4 +: 4];
              model_ack[i]   <= 1'b1;
              model_rdata[i] <= wrt[i][ma] ? regs[i][ma] : dflt(i, ma);
              if (!fll_web_o[i]) begin
                regs[i][ma] <= fll_wdata_o[i*32 +: 32];
                wrt[i][ma]  <= 1'b1;
              end
            end
          end
        end else if (!fll_req_o[i]) begin
          cnt[i]       <= 0;
          model_ack[i] <= 1'b0;
        end
      end
    end
  end

  assign fll_ack_i = model_ack | force_ack;
  for (genvar g = 0; g < NUM; g++) begin : g_rd
    assign fll_rdata_i[g*32 +: 32] = model_rdata[g];
  end

  // ---------------- no-overlap monitor: a new req may only rise once every other ack is long low
  int             ack_low_cnt [NUM] = '{default: 100};
  logic [NUM-1:0] prev_req = '0;

  always @(negedge clk_i) begin
    for (int c = 0; c < NUM; c++) begin
      if (fll_req_o[c] && !prev_req[c]) begin
        for (int j = 0; j < NUM; j++) begin
          if (j != c) check($sformatf("no_overlap ch%0d vs ch%0d", c, j),
                            128'(ack_low_cnt[j] >= SYNC), 128'(1));
        end
      end
    end
    prev_req = fll_req_o;
    for (int j = 0; j < NUM; j++) ack_low_cnt[j] = fll_ack_i[j] ? 0 : ack_low_cnt[j] + 1;
  end

  // ---------------- scoreboard and APB driver
  typedef struct {
    logic [31:0] rd;
    bit          err;
    int          lat;
    string       name;
  } exp_t;
  exp_t sb_q [$];

  typedef struct {
    string       name;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
    int          lat;
    int          gap;
  } vec_t;

  function automatic logic [11:0] mk(input int ch, input int rg);
    return 12'((ch << 6) | (rg << 2));
  endfunction

  task automatic xfer(input string name, input bit wr, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input bit err,
                      input int lat, input int gap);
    exp_t       e;
    bit         got, seen;
    int         ch;
    logic [3:0] ew;
    e = '{rd: rd, err: err, lat: lat, name: name};
    sb_q.push_back(e);
    ch = int'(addr[7:6]);
    ew = 4'hF;
    ew[ch] = ~wr;
    repeat (gap) @(posedge clk_i);
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wd;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    got = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      if (!seen && fll_req_o != '0) begin
        seen = 1'b1;
        check({name, "/req_web"}, 128'({fll_req_o, fll_web_o}), 128'({4'(1 << ch), ew}));
        check({name, "/addr_wdata"}, 128'({fll_addr_o[ch*4 +: 4], fll_wdata_o[ch*32 +: 32]}),
              128'({addr[5:2], wd}));
      end
      if (pready_o) begin
        got = 1'b1;
        e = sb_q.pop_front();
        check({e.name, "/err_rdata"}, 128'({pslverr_o, prdata_o}), 128'({e.err, e.rd}));
        if (e.lat >= 0) check({e.name, "/latency"}, 128'(i), 128'(e.lat));
        if (e.lat == 0) check({e.name, "/no_req"}, 128'(seen), 128'(0));
      end
    end
    if (!got) begin
      e = sb_q.pop_front();
      check({e.name, "/pready_timeout"}, 128'(0), 128'(1));
    end
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0; pwdata_i = '0;
    @(negedge clk_i);
    check({name, "/req_dropped"}, 128'(fll_req_o), 128'(0));
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{"wr_ch2_r5",     1, mk(2, 5),            32'hDEAD_BEEF, 32'h0,         0, 6,  0};
    vecs[1] = '{"rd_ch1_r3",     0, mk(1, 3),            32'h0,         32'h1234_5678, 0, 7,  3};
    vecs[2] = '{"rd_ch2_r5",     0, mk(2, 5),            32'h0,         32'hDEAD_BEEF, 0, 6,  3};
    vecs[3] = '{"wr_ch0_r0",     1, mk(0, 0),            32'hA5A5_0001, 32'h0,         0, 5,  3};
    vecs[4] = '{"b2b_rd_ch3_rf", 0, mk(3, 15),           32'h0,         32'hC0FF_EE03, 0, -1, 0};
    vecs[5] = '{"b2b_rd_ch0_r0", 0, mk(0, 0),            32'h0,         32'hA5A5_0001, 0, -1, 0};
    vecs[6] = '{"unmapped_hi",   1, 12'h800 | mk(1, 2),  32'h5555_AAAA, 32'h0,         1, 0,  3};
    vecs[7] = '{"rd_ch3_r0",     0, mk(3, 0),            32'h0,         32'hF11A_0300, 0, 4,  3};
    vecs[8] = '{"wr_ch3_rf",     1, mk(3, 15),           32'h1111_2222, 32'h0,         0, 4,  3};
    vecs[9] = '{"b2b_rd_ch3_rf2",0, mk(3, 15),           32'h0,         32'h1111_2222, 0, -1, 0};

    // reset values
    #3;
    check("reset/apb", 128'({pready_o, pslverr_o, prdata_o}), 128'(0));
    check("reset/req_web", 128'({fll_req_o, fll_web_o}), 128'({4'h0, 4'hF}));
    check("reset/addr", 128'(fll_addr_o), 128'(0));
    check("reset/wdata", 128'(fll_wdata_o), 128'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    // channel 3 is unmapped on a three-channel bridge: immediate error, no request
    @(posedge clk_i); #1;
    psel3 = 1'b1; pwrite_i = 1'b0; paddr_i = mk(3, 1);
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(negedge clk_i);
    check("n3_ch3/resp", 128'({pready3, pslverr3, prdata3}), 128'({1'b1, 1'b1, 32'h0}));
    check("n3_ch3/req", 128'({req3, web3}), 128'({3'b000, 3'b111}));
    @(posedge clk_i); #1;
    psel3 = 1'b0; penable_i = 1'b0; paddr_i = '0;
    @(negedge clk_i);
    check("n3_ch3/req_after", 128'(req3), 128'(0));

    for (int k = 0; k < 10; k++) begin
      xfer(vecs[k].name, vecs[k].wr, vecs[k].addr, vecs[k].wd, vecs[k].rd,
           vecs[k].err, vecs[k].lat, vecs[k].gap);
    end

    // timeout on ch1; a late ack arrives during DRAIN and must hold off the next access
    mute[1] = 1'b1;
    fork
      begin
        @(posedge fll_req_o[1]);
        repeat (14) @(posedge clk_i);
        #1 force_ack[1] = 1'b1;
        repeat (5) @(posedge clk_i);
        #1 force_ack[1] = 1'b0;
      end
    join_none
    xfer("timeout_ch1", 0, mk(1, 4), 32'h0, 32'h0, 1, TO, 3);
    xfer("after_drain_rd_ch0", 0, mk(0, 0), 32'h0, 32'hA5A5_0001, 0, 9, 0);
    mute[1] = 1'b0;
    xfer("after_timeout_rd_ch1", 0, mk(1, 3), 32'h0, 32'h1234_5678, 0, 7, 3);

    // reset while a request is outstanding
    mute[2] = 1'b1;
    @(posedge clk_i); #1;
    psel_i = 1'b1; pwrite_i = 1'b1; paddr_i = mk(2, 7); pwdata_i = 32'h0BAD_F00D;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_mid/req_before", 128'({fll_req_o, fll_web_o}), 128'({4'b0100, 4'b1011}));
    #1 rst_ni = 1'b0;
    #1;
    check("rst_mid/req_web", 128'({fll_req_o, fll_web_o, pready_o}), 128'({4'h0, 4'hF, 1'b0}));
    check("rst_mid/addr_wdata", 128'({fll_addr_o, fll_wdata_o[111:0]}), 128'(0));
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = '0; pwdata_i = '0;
    mute[2] = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    xfer("post_reset_rd_ch2", 0, mk(2, 5), 32'h0, 32'hDEAD_BEEF, 0, 6, 3);
    check("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", nchecks, nerrors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_to_fll_multi.md
Name: apb_to_fll_multi

Overview:
- APB slave bridging one APB port to NUM_FLL independent FLL configuration interfaces, using a 4-phase req/ack handshake with acks synchronised into clk_i.
- Parametrised successor of the single-interface APB-to-FLL bridge: channel select decoded from paddr, configurable synchroniser depth, ack timeout with pslverr, and immediate error on unmapped channel.
- Sits on the SoC peripheral APB bus in front of the FLL/clock-generation cluster.
- ref_clk of every FLL is ≤ clk_i.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width; must be ≥ 6+CH_W.
- NUM_FLL, 4, number of FLL interfaces; range 1..16.
- SYNC_STAGES, 2, flops in each ack synchroniser; ≥ 2.
- TIMEOUT_CYCLES, 1024, clk_i cycles in REQ before abort; 0 disables timeout.
- CH_W, $clog2(NUM_FLL) (min 1), derived, channel-select width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB write.
- paddr_i  in  APB_ADDR_WIDTH  byte address; [5:2] = register index, [6+CH_W-1:6] = channel.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error.
- fll_req_o  out  NUM_FLL  per-channel request.
- fll_web_o  out  NUM_FLL  per-channel write-enable, active-low.
- fll_addr_o  out  NUM_FLL×4  per-channel register index.
- fll_wdata_o  out  NUM_FLL×32  per-channel write data.
- fll_ack_i  in  NUM_FLL  per-channel ack, asynchronous to clk_i.
- fll_rdata_i  in  NUM_FLL×32  per-channel read data; stable while its ack is high.

Interface (already decided):
- Reset rst_ni, asynchronous, active-low; clock clk_i.

Behaviour:
- Reset values:
  - State IDLE; timeout counter 0; all synchroniser flops 0.
  - All outputs 0, except fll_web_o all-ones.
- Access phase: psel_i & penable_i.
  - ch = paddr_i[6+CH_W-1:6].
  - Unmapped when ch ≥ NUM_FLL, or when any paddr bit above 6+CH_W-1 is set.
- Channel outputs:
  - Only channel ch is driven, and only while state=REQ: req=1, web=~pwrite_i, addr=paddr_i[5:2], wdata=pwdata_i.
  - All other channels, and all channels in other states: req=0, web=1, addr=0, wdata=0.
- Ack synchronisation: ack_sync[i] = fll_ack_i[i] delayed through SYNC_STAGES flops. All channels are synchronised continuously.
- FSM states: IDLE, REQ, ACK_LOW, DRAIN.
- IDLE:
  - Access phase with unmapped ch: pready_o=1 and pslverr_o=1 in the same cycle; prdata_o=0; stay in IDLE.
  - Access phase with mapped ch: latch ch into ch_q; clear the timeout counter; go to REQ next cycle.
- REQ:
  - Drive the channel; increment the counter.
  - If ack_sync[ch_q]=1: pready_o=1 and pslverr_o=0 this cycle; prdata_o = fll_rdata_i[ch_q] for reads, 0 for writes; drop req next cycle; go to ACK_LOW.
  - Else if TIMEOUT_CYCLES≠0 and counter = TIMEOUT_CYCLES-1: pready_o=1, pslverr_o=1, prdata_o=0; go to DRAIN.
  - Ack and timeout in the same cycle: ack wins.
- ACK_LOW: req=0; wait until ack_sync[ch_q]=0, then go to IDLE.
- DRAIN:
  - req=0; wait until ack_sync[ch_q]=0, then go to IDLE.
  - A late ack rising in DRAIN is absorbed; no APB response is generated.
- Back-to-back accesses: any APB access arriving in ACK_LOW/DRAIN sees pready_o=0 until the FSM returns to IDLE and the access completes normally.
- Minimum latency (ack returns 1 ref-domain cycle after req): access-phase cycle + 1 (enter REQ) + SYNC_STAGES + FLL response.
- Protocol violation: psel_i dropping while in REQ.
  - The handshake continues, so the FLL is not left with req high mid-cycle.
  - pready_o is gated by psel_i & penable_i, so no response is issued.
  - Channel outputs hold their last values: addr/wdata/web are captured into registers on IDLE→REQ, not taken combinationally from APB.
- pready_o/pslverr_o/prdata_o are 0 whenever not signalling completion.
- Reset mid-transfer: outputs return to reset values immediately (asynchronous). The FLL sees req fall without completion; this is legal for the FLL interface.

Decomposition:
- Package apb_to_fll_multi_pkg:
  - State enum.
  - FLL_REG_IDX_LSB=2, FLL_CH_LSB=6.
  - fll_req_t struct {web, addr[3:0], wdata[31:0]}.
- Sub-module fll_ack_sync: single-bit SYNC_STAGES-deep synchroniser with async reset. Instantiated NUM_FLL times by generate.

Test Plan:
- Write to ch2 reg 5, pwdata 0xDEADBEEF, FLL model acks 3 cycles after req → only fll_req_o[2] high; fll_addr_o[2]=5; web=0; pready=1, pslverr=0; req drops; next access accepted only after ack low.
- Read ch1 reg 3, model returns 0x12345678 → prdata_o=0x12345678 exactly in the pready cycle; pslverr=0.
- NUM_FLL=3, access to ch3 → pready=1, pslverr=1 in the access-phase cycle; all fll_req_o stay 0.
- TIMEOUT_CYCLES=16, model never acks → pready and pslverr in the 16th REQ cycle; then model acks late and releases → no extra pready; FSM back in IDLE; next read succeeds.
- Back-to-back: write ch0 immediately followed by read ch3 → second transfer stalls until ch0 ack_sync low; the two transfers never overlap.
- Reset asserted in REQ → fll_req_o=0 and fll_web_o all-ones immediately; after release, a read completes normally.
